// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier, divider).
// Provides the default operand width and the common 2-bit FSM state encoding
// used by both units so the lab controller can decode either one the same way.
package seq_arith_pkg;

  // Operand width shared with the sequential shift-add multiplier.
  localparam int DEFAULT_WIDTH = 4;

  // FSM states common to the sequential arithmetic units.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Handshake/operand bundle between the arithmetic lab controller and the
// sequential divider.
//   master : controller side - drives start/dividend/divisor, sees status/results
//   slave  : divider side    - consumes the request, drives busy/done/results
interface seq_div_if
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Shifts the next dividend bit into the partial remainder and trial-subtracts
// the divisor; the new quotient bit says whether the subtraction was kept.
//   r_in  : partial remainder before the step (always < d)
//   q_msb : dividend bit being shifted into the remainder
//   d     : divisor
//   r_out : partial remainder after the step
//   q_bit : quotient bit produced by this step
module div_step
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  // Shifted remainder needs one extra bit so the compare cannot overflow.
  logic [WIDTH:0] trial;

  // Trial subtract and restore.
  always_comb begin
    trial = {r_in, q_msb};
    if (trial >= {1'b0, d}) begin
      q_bit = 1'b1;
      // r_in < d implies trial < 2*d, so the difference fits in WIDTH bits
      // and the low WIDTH bits of the modular subtraction are exact.
      r_out = trial[WIDTH-1:0] - d;
    end else begin
      q_bit = 1'b0;
      r_out = trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring (shift-subtract) unsigned divider, one quotient bit per
// clock. A start seen in IDLE latches the operands; WIDTH iterations later the
// quotient/remainder are written and done pulses for one cycle. A zero divisor
// completes immediately with quotient = all ones, remainder = dividend and
// div_by_zero set. Results hold until the next completion or reset.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (abandons any operation in flight)
//   bus : seq_div_if slave - start/dividend/divisor in; busy/done/quotient/
//         remainder/div_by_zero out
module seq_div
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  seq_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;
  logic             divisor_zero;
  logic             busy_dec;
  logic             done_dec;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_in  (r_reg),
    .q_msb (q_reg[WIDTH-1]),
    .d     (d_reg),
    .r_out (step_r),
    .q_bit (step_q)
  );

  assign q_next       = {q_reg[WIDTH-2:0], step_q};
  assign last_iter    = (count == CW'(WIDTH - 1));
  assign divisor_zero = (bus.divisor == {WIDTH{1'b0}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          next_state = divisor_zero ? ST_DONE : ST_DIVIDE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (last_iter) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_DIVIDE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Status decode; both flags come straight from the state flops.
  always_comb begin
    busy_dec = 1'b0;
    done_dec = 1'b0;
    case (state)
      ST_DIVIDE: busy_dec = 1'b1;
      ST_DONE:   done_dec = 1'b1;
      default: begin
        busy_dec = 1'b0;
        done_dec = 1'b0;
      end
    endcase
  end

  // Working registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg         <= {WIDTH{1'b0}};
      r_reg         <= {WIDTH{1'b0}};
      d_reg         <= {WIDTH{1'b0}};
      count         <= {CW{1'b0}};
      quotient_reg  <= {WIDTH{1'b0}};
      remainder_reg <= {WIDTH{1'b0}};
      dbz_reg       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            q_reg <= bus.dividend;
            d_reg <= bus.divisor;
            r_reg <= {WIDTH{1'b0}};
            count <= {CW{1'b0}};
            // Zero divisor skips the iterations and publishes its result now.
            if (divisor_zero) begin
              quotient_reg  <= {WIDTH{1'b1}};
              remainder_reg <= bus.dividend;
              dbz_reg       <= 1'b1;
            end
          end
        end
        ST_DIVIDE: begin
          q_reg <= q_next;
          r_reg <= step_r;
          count <= count + CW'(1);
          if (last_iter) begin
            quotient_reg  <= q_next;
            remainder_reg <= step_r;
            dbz_reg       <= 1'b0;
          end
        end
        default: begin
          q_reg <= q_reg;
        end
      endcase
    end
  end

  assign bus.busy        = busy_dec;
  assign bus.done        = done_dec;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div at WIDTH=4.
module tb_seq_div;
  import seq_arith_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   last_q;
  int   last_r;
  int   last_dbz;
  int   n;
  int   prev_done;

  seq_div_if #(.WIDTH(4)) bus ();

  seq_div #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // lat: cycles of busy between the start edge and the done cycle (0 for /0).
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input int eq, input int er, input int edbz,
                        input int lat, input bit disturb, input string tag);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check({tag, "_busy"}, bus.busy, 1);
      check({tag, "_nodone"}, bus.done, 0);
      check({tag, "_hold_q"}, bus.quotient, last_q);
      check({tag, "_hold_r"}, bus.remainder, last_r);
      check({tag, "_hold_dbz"}, bus.div_by_zero, last_dbz);
      if (disturb) begin
        bus.start    = (i % 2 == 0);
        bus.dividend = 4'd0;
        bus.divisor  = 4'd0;
      end
      tick();
    end
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_done_busy"}, bus.busy, 0);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dbz"}, bus.div_by_zero, edbz);
    if (disturb) bus.start = 1'b1;
    tick();
    check({tag, "_after_done"}, bus.done, 0);
    check({tag, "_after_busy"}, bus.busy, 0);
    bus.start = 1'b0;
    last_q   = eq;
    last_r   = er;
    last_dbz = edbz;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_q   = 0;
    last_r   = 0;
    last_dbz = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);

    run_op(4'd13, 4'd4, 3, 1, 0, 4, 1'b0, "d13_4");
    run_op(4'd15, 4'd1, 15, 0, 0, 4, 1'b0, "d15_1");
    run_op(4'd3, 4'd7, 0, 3, 0, 4, 1'b0, "d3_7");
    run_op(4'd5, 4'd0, 15, 5, 1, 0, 1'b0, "d5_0");
    run_op(4'd9, 4'd2, 4, 1, 0, 4, 1'b0, "d9_2");

    // Abort mid-operation with a reset after two iterations.
    bus.start    = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 32'(dut.state), 32'(ST_IDLE));
    check("abort_busy", bus.busy, 0);
    check("abort_q", bus.quotient, 0);
    check("abort_r", bus.remainder, 0);
    check("abort_dbz", bus.div_by_zero, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort_nodone", bus.done, 0);
      tick();
    end
    last_q   = 0;
    last_r   = 0;
    last_dbz = 0;
    run_op(4'd14, 4'd3, 4, 2, 0, 4, 1'b0, "d14_3");

    // Inputs wiggled while busy and start raised in DONE must be ignored.
    run_op(4'd12, 4'd5, 2, 2, 0, 4, 1'b1, "d12_5_dist");
    check("dist_idle_busy", bus.busy, 0);

    // Sweep all operand pairs with start held high.
    bus.start = 1'b1;
    prev_done = -1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.dividend = 4'(a);
        bus.divisor  = 4'(b);
        tick();
        n = 0;
        while (bus.done !== 1'b1 && n < 8) begin
          tick();
          n++;
        end
        check("sweep_lat", n, (b == 0) ? 0 : 4);
        if (b == 0) begin
          check("sweep_q0", bus.quotient, 15);
          check("sweep_r0", bus.remainder, a);
          check("sweep_dbz0", bus.div_by_zero, 1);
        end else begin
          check("sweep_q", bus.quotient, a / b);
          check("sweep_r", bus.remainder, a % b);
          check("sweep_dbz", bus.div_by_zero, 0);
        end
        if (prev_done >= 0) check("sweep_gap", cyc - prev_done, (b == 0) ? 2 : 6);
        prev_done = cyc;
        tick();
      end
    end
    bus.start = 1'b0;
    tick();
    check("end_busy", bus.busy, 0);
    check("end_done", bus.done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
